alu_seq_exec: RTL and testbench

//   Parametrised multi-cycle ALU with integrated op decode, for the EX stage of the datapath.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq_exec.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq_exec.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX-stage control FSM (master) and the sequential ALU (slave).
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            out_err;

  modport master (
    output in_valid, alu_op, funct3, funct7, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, out_err
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, out_err
  );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle EX-stage ALU: decodes {alu_op, funct3, funct7}, single-cycle logic/arith,
// iterative shifts (SHIFT_STEP bits/cycle) and shift-add MUL behind valid/ready handshakes.
module alu_seq_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int MUL_EN     = 1
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP     = SHIFT_STEP[SHW:0];
  localparam logic [SHW:0] MUL_ITER = XLEN[SHW:0];
  localparam logic [6:0]   F7_BASE  = 7'b0000000;
  localparam logic [6:0]   F7_ALT   = 7'b0100000;
  localparam logic [6:0]   F7_MUL   = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_XOR, OP_OR, OP_AND, OP_MUL
  } op_t;

  state_t          r_state, w_state_nx;
  op_t             r_op, w_op;
  logic            w_ill;
  logic [XLEN-1:0] r_a, r_b, r_acc;
  logic [SHW:0]    r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_zero, r_err;

  logic            w_rtype, w_accept, w_is_shift;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu, w_shifted, w_mul_sum;
  logic [SHW:0]    w_step;

  assign w_rtype    = bus.alu_op[0];
  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_shamt    = bus.operand_b[SHW-1:0];
  assign w_is_shift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);

  // I-type ignores funct7 except on shifts; R-type must match one of the three legal encodings.
  always_comb begin
    w_op  = OP_ADD;
    w_ill = 1'b0;
    case (bus.alu_op)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      default: begin
        case (bus.funct3)
          3'b000: begin
            if (w_rtype) begin
              if (bus.funct7 == F7_ALT) w_op = OP_SUB;
              else if (bus.funct7 == F7_MUL) begin
                w_op  = OP_MUL;
                w_ill = (MUL_EN == 0);
              end else if (bus.funct7 != F7_BASE) w_ill = 1'b1;
            end
          end
          3'b001: begin w_op = OP_SLL;  w_ill = (bus.funct7 != F7_BASE); end
          3'b010: begin w_op = OP_SLT;  w_ill = w_rtype && (bus.funct7 != F7_BASE); end
          3'b011: begin w_op = OP_SLTU; w_ill = w_rtype && (bus.funct7 != F7_BASE); end
          3'b100: begin w_op = OP_XOR;  w_ill = w_rtype && (bus.funct7 != F7_BASE); end
          3'b101: begin
            w_op  = bus.funct7[5] ? OP_SRA : OP_SRL;
            w_ill = (bus.funct7 != F7_BASE) && (bus.funct7 != F7_ALT);
          end
          3'b110: begin w_op = OP_OR;   w_ill = w_rtype && (bus.funct7 != F7_BASE); end
          default: begin w_op = OP_AND; w_ill = w_rtype && (bus.funct7 != F7_BASE); end
        endcase
      end
    endcase
  end

  // Shifts land here only with shamt==0, so the pass-through of operand_a is the full answer.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = bus.operand_a + bus.operand_b;
      OP_SUB:  w_alu = bus.operand_a - bus.operand_b;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(bus.operand_a) < $signed(bus.operand_b)};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, bus.operand_a < bus.operand_b};
      OP_XOR:  w_alu = bus.operand_a ^ bus.operand_b;
      OP_OR:   w_alu = bus.operand_a | bus.operand_b;
      OP_AND:  w_alu = bus.operand_a & bus.operand_b;
      OP_SLL, OP_SRL, OP_SRA: w_alu = bus.operand_a;
      default: w_alu = '0;
    endcase
  end

  assign w_step = (r_cnt > STEP) ? STEP : r_cnt;

  always_comb begin
    w_shifted = '0;
    case (r_op)
      OP_SLL:  w_shifted = r_a << w_step;
      OP_SRL:  w_shifted = r_a >> w_step;
      default: w_shifted = $signed(r_a) >>> w_step;
    endcase
  end

  assign w_mul_sum = r_acc + (r_b[0] ? r_a : '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_ill)                              w_state_nx = S_DONE;
          else if (w_op == OP_MUL)                w_state_nx = S_MUL;
          else if (w_is_shift && (w_shamt != '0)) w_state_nx = S_SHIFT;
          else                                    w_state_nx = S_DONE;
        end
      end
      S_SHIFT: if (r_cnt == w_step)                  w_state_nx = S_DONE;
      S_MUL:   if (r_cnt == (SHW+1)'(1))             w_state_nx = S_DONE;
      default: if (bus.out_ready)                    w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= w_op;
            r_a   <= bus.operand_a;
            r_b   <= bus.operand_b;
            r_acc <= '0;
            r_err <= w_ill;
            if (w_ill) begin
              r_result <= '0;
              r_zero   <= 1'b1;
            end else if (w_op == OP_MUL) begin
              r_cnt <= MUL_ITER;
            end else if (w_is_shift && (w_shamt != '0)) begin
              r_cnt <= {1'b0, w_shamt};
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
            end
          end
        end
        S_SHIFT: begin
          r_a   <= w_shifted;
          r_cnt <= r_cnt - w_step;
          if (r_cnt == w_step) begin
            r_result <= w_shifted;
            r_zero   <= (w_shifted == '0);
          end
        end
        S_MUL: begin
          r_acc <= w_mul_sum;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - (SHW+1)'(1);
          if (r_cnt == (SHW+1)'(1)) begin
            r_result <= w_mul_sum;
            r_zero   <= (w_mul_sum == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.out_err   = r_err;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench: default config, SHIFT_STEP=8 config and MUL_EN=0 config share one request bus.
module tb_alu_seq_exec;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  v = '0;
  logic        rdy = 1'b1;
  logic [1:0]  op = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [31:0] a = '0, b = '0;
  int          n_pass = 0, n_total = 0;
  int          lat;

  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(32)) ifa ();
  alu_seq_if #(.XLEN(32)) ifb ();
  alu_seq_if #(.XLEN(32)) ifc ();

  assign ifa.in_valid = v[0];
  assign ifb.in_valid = v[1];
  assign ifc.in_valid = v[2];
  assign {ifa.alu_op, ifb.alu_op, ifc.alu_op} = {3{op}};
  assign {ifa.funct3, ifb.funct3, ifc.funct3} = {3{f3}};
  assign {ifa.funct7, ifb.funct7, ifc.funct7} = {3{f7}};
  assign {ifa.operand_a, ifb.operand_a, ifc.operand_a} = {3{a}};
  assign {ifa.operand_b, ifb.operand_b, ifc.operand_b} = {3{b}};
  assign {ifa.out_ready, ifb.out_ready, ifc.out_ready} = {3{rdy}};

  alu_seq_exec #(.XLEN(32), .SHIFT_STEP(1), .MUL_EN(1)) dut   (.clk(clk), .reset(reset), .bus(ifa));
  alu_seq_exec #(.XLEN(32), .SHIFT_STEP(8), .MUL_EN(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  alu_seq_exec #(.XLEN(32), .SHIFT_STEP(1), .MUL_EN(0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  function automatic logic ov(input int s);
    case (s)
      0: return ifa.out_valid;
      1: return ifb.out_valid;
      default: return ifc.out_valid;
    endcase
  endfunction

  function automatic logic ir(input int s);
    case (s)
      0: return ifa.in_ready;
      1: return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits for in_ready, then holds in_valid across exactly one rising edge (the accept edge).
  task automatic issue(input int s, input logic [1:0] op_i, input logic [2:0] f3_i,
                       input logic [6:0] f7_i, input logic [31:0] a_i, input logic [31:0] b_i);
    int k = 0;
    while (!ir(s) && k < 100) begin @(posedge clk); #1; k++; end
    op = op_i; f3 = f3_i; f7 = f7_i; a = a_i; b = b_i;
    v[s] = 1'b1;
    @(posedge clk); #1;
    v[s] = 1'b0;
  endtask

  // Returns k such that out_valid first appears in cycle N+k.
  task automatic wait_out(input int s, output int l);
    l = 1;
    while (!ov(s) && l < 100) begin @(posedge clk); #1; l++; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(ifa.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_result",    ifa.result, 32'd0);
    chk("rst_zero",      32'(ifa.zero), 32'd0);
    chk("rst_err",       32'(ifa.out_err), 32'd0);
    reset = 1'b0;

    issue(0, 2'b00, 3'b000, 7'h00, 32'd5, 32'd7);
    wait_out(0, lat);
    chk("add_lat", lat, 1); chk("add_res", ifa.result, 32'd12);
    chk("add_zero", 32'(ifa.zero), 0); chk("add_err", 32'(ifa.out_err), 0);

    issue(0, 2'b01, 3'b000, 7'h00, 32'h1234, 32'h1234);
    wait_out(0, lat);
    chk("sub_lat", lat, 1); chk("sub_res", ifa.result, 0); chk("sub_zero", 32'(ifa.zero), 1);

    issue(0, 2'b11, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'd1);
    wait_out(0, lat);
    chk("add_wrap_res", ifa.result, 0); chk("add_wrap_zero", 32'(ifa.zero), 1);

    issue(0, 2'b10, 3'b101, 7'b0100000, 32'h8000_0000, 32'd31);
    wait_out(0, lat);
    chk("srai_lat", lat, 32); chk("srai_res", ifa.result, 32'hFFFF_FFFF);

    issue(1, 2'b10, 3'b101, 7'b0100000, 32'h8000_0000, 32'd31);
    wait_out(1, lat);
    chk("srai8_lat", lat, 5); chk("srai8_res", ifb.result, 32'hFFFF_FFFF);

    issue(0, 2'b10, 3'b001, 7'h00, 32'd1, 32'd4);
    wait_out(0, lat);
    chk("slli_lat", lat, 5); chk("slli_res", ifa.result, 32'd16);

    issue(1, 2'b10, 3'b001, 7'h00, 32'd1, 32'd4);
    wait_out(1, lat);
    chk("slli8_lat", lat, 2); chk("slli8_res", ifb.result, 32'd16);

    issue(0, 2'b11, 3'b101, 7'h00, 32'h8000_0000, 32'd9);
    wait_out(0, lat);
    chk("srl_lat", lat, 10); chk("srl_res", ifa.result, 32'h0040_0000);

    // shamt field of 0x20 is zero: pass-through in one cycle
    issue(0, 2'b11, 3'b101, 7'h00, 32'hABCD, 32'h20);
    wait_out(0, lat);
    chk("srl0_lat", lat, 1); chk("srl0_res", ifa.result, 32'hABCD);

    issue(0, 2'b11, 3'b000, 7'b0000001, 32'h0000_FFFF, 32'h0001_0001);
    wait_out(0, lat);
    chk("mul_lat", lat, 33); chk("mul_res", ifa.result, 32'hFFFF_FFFF); chk("mul_err", 32'(ifa.out_err), 0);

    issue(0, 2'b11, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1);
    wait_out(0, lat);
    chk("slt_res", ifa.result, 32'd1);

    issue(0, 2'b11, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1);
    wait_out(0, lat);
    chk("sltu_res", ifa.result, 32'd0); chk("sltu_zero", 32'(ifa.zero), 1);

    issue(0, 2'b10, 3'b100, 7'h55, 32'hF0F0, 32'h0FF0);
    wait_out(0, lat);
    chk("xori_res", ifa.result, 32'hFF00); chk("xori_err", 32'(ifa.out_err), 0);

    issue(0, 2'b11, 3'b000, 7'b0000010, 32'd3, 32'd4);
    wait_out(0, lat);
    chk("ill_lat", lat, 1); chk("ill_res", ifa.result, 0);
    chk("ill_zero", 32'(ifa.zero), 1); chk("ill_err", 32'(ifa.out_err), 1);

    issue(2, 2'b11, 3'b000, 7'b0000001, 32'd3, 32'd4);
    wait_out(2, lat);
    chk("nomul_lat", lat, 1); chk("nomul_res", ifc.result, 0); chk("nomul_err", 32'(ifc.out_err), 1);

    // Back-pressure: result held while a competing request is ignored
    rdy = 1'b0;
    issue(0, 2'b11, 3'b111, 7'h00, 32'hF0, 32'h3C);
    wait_out(0, lat);
    op = 2'b00; a = 32'd100; b = 32'd1; v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(ifa.out_valid), 1);
      chk("hold_ready", 32'(ifa.in_ready), 0);
      chk("hold_res",   ifa.result, 32'h30);
      @(posedge clk); #1;
    end
    v[0] = 1'b0;
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("rel_valid", 32'(ifa.out_valid), 0);
    chk("rel_ready", 32'(ifa.in_ready), 1);
    @(posedge clk); #1;
    chk("rel_idle", 32'(ifa.out_valid), 0);
    chk("rel_res",  ifa.result, 32'h30);

    issue(0, 2'b11, 3'b000, 7'b0000001, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rmul_valid", 32'(ifa.out_valid), 0);
    chk("rmul_ready", 32'(ifa.in_ready), 1);
    chk("rmul_res",   ifa.result, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("rmul_quiet", 32'(ifa.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
